// File: rtl/dac_writer.sv
// Round-robin writer for a 4-channel, 8-bit parallel DAC.
// Fabric writes land in per-channel shadow registers, which are drained one at a time using setup/strobe/hold bus timing.
module dac_writer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_ch,
  input  logic [7:0] wr_data,
  output logic [7:0] dac_data,
  output logic [1:0] dac_addr,
  output logic       dac_wr_n,
  output logic       busy,
  output logic [3:0] pending
);

  localparam bit CFG_OK = (SETUP_CYC  >= 1) && (SETUP_CYC  <= 15) &&
                          (STROBE_CYC >= 1) && (STROBE_CYC <= 15) &&
                          (HOLD_CYC   >= 1) && (HOLD_CYC   <= 15);

  // Each phase counter is loaded with (cycles - 1) and exits the phase when it reaches zero.
  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] pending_q, pending_d;
  logic [7:0] shadow_q [4];
  logic [7:0] shadow_d [4];
  logic [7:0] data_q, data_d;
  logic [1:0] addr_q, addr_d;
  logic       wr_n_q, wr_n_d;

  logic       accept;
  logic       sel_valid;
  logic [1:0] sel_ch;

  assign wr_ready = ~rst;
  assign accept   = wr_valid & wr_ready;

  // Round-robin search starting just above the last served channel; i == 4 wraps back to ptr itself.
  always_comb begin
    logic [1:0] idx;
    sel_valid = 1'b0;
    sel_ch    = ptr_q;
    idx       = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!sel_valid && pending_q[idx]) begin
        sel_valid = 1'b1;
        sel_ch    = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wr_n_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          data_d            = shadow_q[sel_ch];
          addr_d            = sel_ch;
          pending_d[sel_ch] = 1'b0;
          ptr_d             = sel_ch;
          cnt_d             = SETUP_LOAD;
          state_d           = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = STROBE_LOAD;
          state_d = ST_STROBE;
          wr_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          wr_n_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after arbitration so a same-edge write to the selected channel keeps it pending.
    if (accept) begin
      shadow_d[wr_ch]  = wr_data;
      pending_d[wr_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      ptr_q     <= 2'd3;
      pending_q <= 4'd0;
      data_q    <= 8'd0;
      addr_q    <= 2'd0;
      wr_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      wr_n_q    <= wr_n_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
    always_ff @(posedge clk_in) begin
      if (rst) begin
        shadow_q[gi] <= 8'd0;
      end else begin
        shadow_q[gi] <= shadow_d[gi];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    assert (CFG_OK)
      else $error("dac_writer: SETUP_CYC/STROBE_CYC/HOLD_CYC must each be within 1..15");
  end

  assign dac_data = data_q;
  assign dac_addr = addr_q;
  assign dac_wr_n = wr_n_q;
  assign busy     = (state_q != ST_IDLE);
  assign pending  = pending_q;

endmodule

// File: tb/tb_dac_writer.sv
// Self-checking bench for dac_writer: vector table for single writes plus hand-built multi-cycle sequences,
// with a strobe monitor that pops expected {addr,data} pairs from a scoreboard queue.
module tb_dac_writer;

  localparam int SETUP_CYC  = 2;
  localparam int STROBE_CYC = 2;
  localparam int HOLD_CYC   = 1;
  localparam int BUSY_CYC   = SETUP_CYC + STROBE_CYC + HOLD_CYC;
  localparam int WRITE_CYC  = 1 + BUSY_CYC;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_ch = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] dac_data;
  logic [1:0] dac_addr;
  logic       dac_wr_n;
  logic       busy;
  logic [3:0] pending;

  dac_writer #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .dac_data(dac_data),
    .dac_addr(dac_addr),
    .dac_wr_n(dac_wr_n),
    .busy    (busy),
    .pending (pending)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic [3:0] exp_pending;
  } vec_t;

  wr_t  sb [$];
  int   strobe_t [$];
  int   fair_addr [$];
  int   fair_data [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  bit   sb_off = 1'b0;
  bit   fair_rec = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor, sampling 1 time unit after each rising edge.
  logic       prev_wr_n = 1'b1;
  bit         in_strobe = 1'b0;
  int         low_len = 0;
  logic [1:0] s_addr;
  logic [7:0] s_data;
  wr_t        exp_wr;

  always @(posedge clk_in) begin
    #1;
    cyc++;
    if (rst) begin
      in_strobe = 1'b0;
      prev_wr_n = 1'b1;
    end else begin
      if (prev_wr_n && !dac_wr_n) begin
        in_strobe = 1'b1;
        low_len   = 1;
        s_addr    = dac_addr;
        s_data    = dac_data;
        strobe_cnt++;
        strobe_t.push_back(cyc);
        if (fair_rec) begin
          fair_addr.push_back(int'(dac_addr));
          fair_data.push_back(int'(dac_data));
        end
        if (!sb_off) begin
          if (sb.size() == 0) begin
            check("unexpected_strobe", int'({dac_addr, dac_data}), 0);
          end else begin
            exp_wr = sb.pop_front();
            $display("strobe @%0d addr=%0d data=0x%02h (expected addr=%0d data=0x%02h)",
                     cyc, dac_addr, dac_data, exp_wr.addr, exp_wr.data);
            check("strobe_addr", int'(dac_addr), int'(exp_wr.addr));
            check("strobe_data", int'(dac_data), int'(exp_wr.data));
          end
        end
      end else if (!dac_wr_n && in_strobe) begin
        low_len++;
        check("strobe_addr_stable", int'(dac_addr), int'(s_addr));
        check("strobe_data_stable", int'(dac_data), int'(s_data));
      end else if (dac_wr_n && !prev_wr_n && in_strobe) begin
        check("strobe_len", low_len, STROBE_CYC);
        check("hold_addr_stable", int'(dac_addr), int'(s_addr));
        check("hold_data_stable", int'(dac_data), int'(s_data));
        in_strobe = 1'b0;
      end
      prev_wr_n = dac_wr_n;
    end
  end

  // Call at a falling edge; leaves wr_valid high across the next rising edge.
  task automatic drive(input logic [1:0] ch, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_data  = d;
    @(negedge clk_in);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || pending != 4'd0) && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    check(name, (n >= 400) ? 1 : 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs [5];

  initial begin
    vecs[0] = '{2'd2, 8'hA5, 4'b0100};
    vecs[1] = '{2'd0, 8'h5A, 4'b0001};
    vecs[2] = '{2'd3, 8'hFF, 4'b1000};
    vecs[3] = '{2'd1, 8'h00, 4'b0010};
    vecs[4] = '{2'd3, 8'h01, 4'b1000};

    // Reset state; a request held during reset must not be accepted.
    rst = 1'b1;
    repeat (2) @(negedge clk_in);
    wr_valid = 1'b1;
    wr_ch    = 2'd1;
    wr_data  = 8'hEE;
    @(negedge clk_in);
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_dac_data", int'(dac_data), 0);
    check("rst_dac_addr", int'(dac_addr), 0);
    check("rst_dac_wr_n", int'(dac_wr_n), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);
    rst      = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk_in);
    check("post_rst_wr_ready", int'(wr_ready), 1);
    check("post_rst_pending", int'(pending), 0);
    check("post_rst_busy", int'(busy), 0);

    // Table: single writes from IDLE with cycle-exact strobe/busy profile.
    for (int v = 0; v < 5; v++) begin
      sb.push_back('{vecs[v].ch, vecs[v].data});
      drive(vecs[v].ch, vecs[v].data);
      wr_valid = 1'b0;
      check("vec_pending_after_accept", int'(pending), int'(vecs[v].exp_pending));
      check("vec_busy_after_accept", int'(busy), 0);
      for (int k = 1; k <= WRITE_CYC; k++) begin
        @(negedge clk_in);
        check("vec_wr_n", int'(dac_wr_n),
              ((k >= 1 + SETUP_CYC) && (k <= SETUP_CYC + STROBE_CYC)) ? 0 : 1);
        check("vec_busy", int'(busy), (k <= BUSY_CYC) ? 1 : 0);
        if (k == 1) begin
          check("vec_dac_addr", int'(dac_addr), int'(vecs[v].ch));
          check("vec_dac_data", int'(dac_data), int'(vecs[v].data));
          check("vec_pending_cleared", int'(pending), 0);
        end
      end
    end

    // Three consecutive writes from IDLE: order 0,1,3, one full write period apart.
    strobe_t.delete();
    strobe_cnt = 0;
    sb.push_back('{2'd0, 8'h11});
    sb.push_back('{2'd1, 8'h22});
    sb.push_back('{2'd3, 8'h33});
    drive(2'd0, 8'h11);
    drive(2'd1, 8'h22);
    drive(2'd3, 8'h33);
    wr_valid = 1'b0;
    wait_idle("burst3_timeout");
    check("burst3_strobes", strobe_cnt, 3);
    if (strobe_t.size() == 3) begin
      check("burst3_gap01", strobe_t[1] - strobe_t[0], WRITE_CYC);
      check("burst3_gap13", strobe_t[2] - strobe_t[1], WRITE_CYC);
    end

    // Coalescing: ch1 rewritten while ch0 is in flight yields one write with the last value.
    strobe_cnt = 0;
    sb.push_back('{2'd0, 8'h01});
    sb.push_back('{2'd1, 8'h30});
    drive(2'd0, 8'h01);
    drive(2'd1, 8'h10);
    wr_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    drive(2'd1, 8'h20);
    drive(2'd1, 8'h30);
    wr_valid = 1'b0;
    check("coalesce_busy_ch0", int'(busy), 1);
    check("coalesce_addr_ch0", int'(dac_addr), 0);
    wait_idle("coalesce_timeout");
    check("coalesce_strobes", strobe_cnt, 2);

    // Accept on the same edge that IDLE selects the channel: old value first, new value on a second pass.
    strobe_cnt = 0;
    sb.push_back('{2'd1, 8'h3F});
    sb.push_back('{2'd1, 8'h40});
    drive(2'd1, 8'h3F);
    drive(2'd1, 8'h40);
    wr_valid = 1'b0;
    check("sameedge_pending", int'(pending), 4'b0010);
    check("sameedge_busy", int'(busy), 1);
    check("sameedge_data", int'(dac_data), 8'h3F);
    wait_idle("sameedge_timeout");
    check("sameedge_strobes", strobe_cnt, 2);

    // Reset during STROBE abandons the write and clears pending state.
    sb.push_back('{2'd2, 8'h99});
    drive(2'd2, 8'h99);
    drive(2'd3, 8'h55);
    wr_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (dac_wr_n && n < 50) begin
        @(negedge clk_in);
        n++;
      end
      check("strobe_wait_timeout", (n >= 50) ? 1 : 0, 0);
    end
    check("pre_rst_pending", int'(pending), 4'b1000);
    rst = 1'b1;
    @(negedge clk_in);
    check("midrst_wr_n", int'(dac_wr_n), 1);
    check("midrst_pending", int'(pending), 0);
    check("midrst_data", int'(dac_data), 0);
    check("midrst_addr", int'(dac_addr), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_wr_ready", int'(wr_ready), 0);
    check("midrst_sb_empty", sb.size(), 0);
    rst = 1'b0;
    @(negedge clk_in);
    strobe_cnt = 0;
    sb.push_back('{2'd0, 8'h7E});
    drive(2'd0, 8'h7E);
    wr_valid = 1'b0;
    wait_idle("postrst_timeout");
    check("postrst_strobes", strobe_cnt, 1);

    // Fairness: ch0 and ch3 kept pending continuously; strobes must alternate.
    sb_off = 1'b1;
    fair_rec = 1'b1;
    fair_addr.delete();
    fair_data.delete();
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) drive(2'd0, 8'(i) & 8'h7F);
      else            drive(2'd3, 8'(i) | 8'h80);
    end
    fair_rec = 1'b0;
    wr_valid = 1'b0;
    wait_idle("fair_timeout");
    sb_off = 1'b0;
    check("fair_count_ok", (fair_addr.size() >= 10) ? 1 : 0, 1);
    for (int i = 0; i < fair_addr.size(); i++) begin
      check("fair_addr_set", ((fair_addr[i] == 0) || (fair_addr[i] == 3)) ? 1 : 0, 1);
      check("fair_data_channel", (fair_data[i] >> 7) & 1, (fair_addr[i] == 3) ? 1 : 0);
      if (i > 0) check("fair_alternate", (fair_addr[i] != fair_addr[i-1]) ? 1 : 0, 1);
    end

    repeat (3) @(negedge clk_in);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
